sram_dp_param: RTL
==================

SRAM_DP_PARAM -- requirements
Module: sram_dp_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data word width in bits; legal values are multiples of 8 in the range 8..128.
REQ-002 SHALL have parameter DEPTH, default 4096: number of words; legal values are powers of 2 in the range 16..65536.
REQ-003 SHALL have parameter RD_LAT, default 1: request-to-ready latency in cycles; legal range 1..4.
REQ-004 SHALL have localparam ADDR_W = $clog2(DEPTH) and localparam BE_W = DATA_W/8.
REQ-005 SHALL have clk  input  1: single clock; all logic on its rising edge.
REQ-006 SHALL have rst_n  input  1: reset, synchronous, active-low.
REQ-007 SHALL have a_read  input  1: port A read request.
REQ-008 SHALL have a_write  input  1: port A write request.
REQ-009 SHALL have a_addr  input  ADDR_W: port A word address.
REQ-010 SHALL have a_byteSel  input  BE_W: port A byte-lane write enables; bit i selects byte lane [8i+7:8i].
REQ-011 SHALL have a_dataD  input  DATA_W: port A write data.
REQ-012 SHALL have a_dataQ  output  DATA_W: port A read data.
REQ-013 SHALL have a_ready  output  1: port A completion pulse.
REQ-014 SHALL have b_read  input  1: port B read request; port B is read-only and serves instruction fetch.
REQ-015 SHALL have b_addr  input  ADDR_W: port B word address.
REQ-016 SHALL have b_dataQ  output  DATA_W: port B read data.
REQ-017 SHALL have b_ready  output  1: port B completion pulse.

Function
REQ-018 SHALL accept a request on a port at every rising edge where that port's read (or A write) is high, with no stall and no backpressure, one request per port per cycle.
REQ-019 SHALL, for a request accepted at edge T, drive that port's ready high for exactly the cycle following edge T+RD_LAT-1, so that ready is sampled high at edge T+RD_LAT.
REQ-020 SHALL keep ready low in any cycle with no completing request; back-to-back requests SHALL give back-to-back ready pulses.
REQ-021 SHALL drive dataQ with the memory word for a completing read, and with all zeros during a write completion or when ready is low.
REQ-022 SHALL treat a_read and a_write high together as a write only.
REQ-023 SHALL, on a port A write, update only the byte lanes whose a_byteSel bit is 1; a_byteSel = 0 SHALL leave memory unchanged and still produce an a_ready pulse.
REQ-024 SHALL sample read data at the acceptance edge and delay it by RD_LAT-1 additional pipeline stages; the total latency SHALL be independent of which port issued the request.
REQ-025 SHALL give read-old-data semantics when port B reads an address that port A writes in the same cycle (b_dataQ returns the pre-write word).
REQ-026 SHALL give read-old-data semantics when port A reads and writes the same address in the same cycle (impossible by REQ-022; no forwarding is required).
REQ-027 SHALL make a write accepted at edge T visible to any read accepted at edge T+1 or later on either port.
REQ-028 SHALL keep ports A and B fully independent in timing; simultaneous requests SHALL never delay each other.

Reset
REQ-029 SHALL, while rst_n is low at a rising edge, clear all pipeline valid bits and data stages, drive a_ready = b_ready = 0 and a_dataQ = b_dataQ = 0 from the next cycle, and ignore all requests.
REQ-030 SHALL drop requests that are in flight when reset is asserted: no ready pulse is produced for them, and memory contents are not cleared or initialised by reset.

Structure
REQ-031 SHALL place the default constants (DATA_W, DEPTH, RD_LAT) and their legal ranges in shared package sram_pkg, and SHALL check parameter legality with an elaboration-time assertion.
REQ-032 SHALL implement the latency delay line (valid + data, RD_LAT stages) as sub-module sram_lat_pipe, instantiated once per port.

Verification
REQ-033 SHALL verify, with RD_LAT=1: write 0xDEADBEEF to address 5 with byteSel=4'hF, then read address 5 -> a_dataQ=0xDEADBEEF with a_ready high exactly 1 cycle after acceptance.
REQ-034 SHALL verify byte lanes: address 7 holds 0x11223344; write 0xAABBCCDD with byteSel=4'b0101 -> a subsequent read returns 0x11BB33DD.
REQ-035 SHALL verify the collision case: in one cycle A writes 0x0 to address 9 (old value 0x12345678) and B reads address 9 -> b_dataQ=0x12345678; a B read on the next cycle returns 0x0.
REQ-036 SHALL verify, with RD_LAT=3: 4 back-to-back B reads of addresses 0..3 -> 4 consecutive b_ready cycles starting at acceptance+3, with data in address order.
REQ-037 SHALL verify reset mid-flight: with RD_LAT=3, issue an A read and drop rst_n one cycle later for 1 cycle -> no a_ready pulse, a_dataQ=0, and memory contents unchanged afterwards.

Source files
------------

// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_pkg
// Purpose  : Shared defaults, legal parameter ranges and a legality helper
//            for the dual-port parameterised SRAM.
// Ports    : (package, no ports)
// Revision : 1.0 - initial release
// ============================================================================
package sram_pkg;

  // Default configuration
  localparam int c_DATA_W_DEF = 32;
  localparam int c_DEPTH_DEF  = 4096;
  localparam int c_RD_LAT_DEF = 1;

  // Legal ranges
  localparam int c_DATA_W_MIN = 8;
  localparam int c_DATA_W_MAX = 128;
  localparam int c_DEPTH_MIN  = 16;
  localparam int c_DEPTH_MAX  = 65536;
  localparam int c_RD_LAT_MIN = 1;
  localparam int c_RD_LAT_MAX = 4;

  // True when the configuration is within the supported envelope.
  function automatic bit sram_params_legal(input int data_w, input int depth,
                                           input int rd_lat);
    bit ok;
    ok = 1'b1;
    if (data_w < c_DATA_W_MIN || data_w > c_DATA_W_MAX || (data_w % 8) != 0)
      ok = 1'b0;
    if (depth < c_DEPTH_MIN || depth > c_DEPTH_MAX || (depth & (depth - 1)) != 0)
      ok = 1'b0;
    if (rd_lat < c_RD_LAT_MIN || rd_lat > c_RD_LAT_MAX)
      ok = 1'b0;
    return ok;
  endfunction

endpackage : sram_pkg
`default_nettype wire

// File: rtl/sram_lat_pipe.sv
`default_nettype none
// ============================================================================
// Module   : sram_lat_pipe
// Purpose  : Completion delay line (valid + data) of RD_LAT register stages.
//            Stage 0 captures at the acceptance edge; the last stage drives
//            the port's ready/dataQ outputs.
// Ports    : clk      - clock, rising edge
//            rst_n    - synchronous active-low reset, clears every stage
//            i_valid  - request accepted this edge
//            i_data   - read word (zero for writes / idle)
//            o_valid  - completion pulse
//            o_data   - completion data
// Revision : 1.0 - initial release
// ============================================================================
module sram_lat_pipe #(
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid [RD_LAT];
  logic [DATA_W-1:0] r_data  [RD_LAT];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < RD_LAT; s++) begin
        r_valid[s] <= 1'b0;
        r_data[s]  <= '0;
      end
    end else begin
      r_valid[0] <= i_valid;
      r_data[0]  <= i_data;
      for (int s = 1; s < RD_LAT; s++) begin
        r_valid[s] <= r_valid[s-1];
        r_data[s]  <= r_data[s-1];
      end
    end
  end

  assign o_valid = r_valid[RD_LAT-1];
  assign o_data  = r_data[RD_LAT-1];

endmodule : sram_lat_pipe
`default_nettype wire

// File: rtl/sram_dp_param.sv
`default_nettype none
// ============================================================================
// Module   : sram_dp_param
// Purpose  : Dual-port SRAM. Port A read/write with byte lanes, port B
//            read-only (instruction fetch). Fixed RD_LAT request-to-ready
//            latency, no backpressure, read-old-data on collisions.
// Ports    : clk, rst_n                 - clock / sync active-low reset
//            a_read, a_write, a_addr,
//            a_byteSel, a_dataD         - port A request
//            a_dataQ, a_ready           - port A completion
//            b_read, b_addr             - port B request
//            b_dataQ, b_ready           - port B completion
// Revision : 1.0 - initial release
// ============================================================================
module sram_dp_param
  import sram_pkg::*;
#(
  parameter  int DATA_W = c_DATA_W_DEF,
  parameter  int DEPTH  = c_DEPTH_DEF,
  parameter  int RD_LAT = c_RD_LAT_DEF,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_read,
  input  logic              a_write,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [BE_W-1:0]   a_byteSel,
  input  logic [DATA_W-1:0] a_dataD,
  output logic [DATA_W-1:0] a_dataQ,
  output logic              a_ready,
  input  logic              b_read,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_dataQ,
  output logic              b_ready
);

  generate
    if (!sram_params_legal(DATA_W, DEPTH, RD_LAT)) begin : g_param_check
      $error("sram_dp_param: illegal parameters DATA_W=%0d DEPTH=%0d RD_LAT=%0d",
             DATA_W, DEPTH, RD_LAT);
    end
  endgenerate

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Requests are ignored while reset is asserted; a write wins over a read.
  logic              w_a_wr;
  logic              w_a_rd;
  logic              w_b_rd;
  logic              w_a_valid;
  logic [DATA_W-1:0] w_a_word;
  logic [DATA_W-1:0] w_b_word;

  assign w_a_wr    = rst_n & a_write;
  assign w_a_rd    = rst_n & a_read & ~a_write;
  assign w_b_rd    = rst_n & b_read;
  assign w_a_valid = w_a_wr | w_a_rd;

  // Memory is read combinationally and captured by pipe stage 0 on the same
  // edge that commits a write, so a colliding read returns the old word.
  assign w_a_word = w_a_rd ? r_mem[a_addr] : '0;
  assign w_b_word = w_b_rd ? r_mem[b_addr] : '0;

  // Memory contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_a_wr) begin
      for (int i = 0; i < BE_W; i++) begin
        if (a_byteSel[i]) begin
          r_mem[a_addr][8*i +: 8] <= a_dataD[8*i +: 8];
        end
      end
    end
  end

  sram_lat_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_pipe_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_a_valid),
    .i_data  (w_a_word),
    .o_valid (a_ready),
    .o_data  (a_dataQ)
  );

  sram_lat_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_pipe_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_b_rd),
    .i_data  (w_b_word),
    .o_valid (b_ready),
    .o_data  (b_dataQ)
  );

endmodule : sram_dp_param
`default_nettype wire
